// File: rtl/cobs_sample_framer_if.sv
// Valid/ready byte or word stream between the sample source, the framer and the FIFO writer.
interface cobs_sample_framer_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cobs_sample_framer.sv
// Packs 32-bit samples into fixed-length 0x00-delimited COBS frames; code byte 1 cycle after block close.
// Output byte/valid registered and held under m.tready=0; s.tready only while collecting with the hold empty.
module cobs_sample_framer #(
  parameter int SAMPLES_PER_FRAME = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cobs_sample_framer_if.slave   s,
  cobs_sample_framer_if.master  m
);
  typedef enum logic [1:0] {COLLECT, EMIT_CODE, EMIT_DATA, EMIT_DELIM} state_e;

  localparam logic [5:0] LAST_SMP = 6'(SAMPLES_PER_FRAME - 1);

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        held_q, held_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  rd_q, rd_d;
  logic [5:0]  smp_q, smp_d;
  logic        final_q, final_d;
  logic        tail_q, tail_d;
  logic [7:0]  m_dat_q, m_dat_d;
  logic        m_vld_q, m_vld_d;
  logic [7:0]  blk_q [252];
  logic        blk_we;
  logic        post;
  logic [7:0]  cur_byte;
  logic        m_hs, s_hs;

  assign s.tready = (state_q == COLLECT) && !held_q;
  assign m.tdata  = m_dat_q;
  assign m.tvalid = m_vld_q;
  assign m_hs     = m_vld_q && m.tready;
  assign s_hs     = s.tvalid && s.tready;
  assign cur_byte = hold_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    held_d  = held_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    smp_d   = smp_q;
    final_d = final_q;
    tail_d  = tail_q;
    blk_we  = 1'b0;
    post    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_hs) begin
          hold_d = s.tdata;
          held_d = 1'b1;
          idx_d  = 2'd0;
        end else if (held_q) begin
          idx_d = idx_q + 2'd1;
          if (cur_byte != 8'h00) begin
            blk_we = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            state_d = EMIT_CODE;
            final_d = 1'b0;
          end
          if (idx_q == 2'd3) begin
            held_d = 1'b0;
            if (smp_q == LAST_SMP) begin
              // A trailing zero still owes the frame a closing empty block.
              if (cur_byte != 8'h00) begin
                state_d = EMIT_CODE;
                final_d = 1'b1;
              end else begin
                tail_d = 1'b1;
              end
            end else begin
              smp_d = smp_q + 6'd1;
            end
          end
        end
      end
      EMIT_CODE: begin
        if (m_hs) begin
          if (cnt_q != 8'd0) state_d = EMIT_DATA;
          else               post    = 1'b1;
        end
      end
      EMIT_DATA: begin
        if (m_hs) begin
          if (rd_q == cnt_q - 8'd1) post = 1'b1;
          else                      rd_d = rd_q + 8'd1;
        end
      end
      EMIT_DELIM: begin
        if (m_hs) begin
          final_d = 1'b0;
          smp_d   = 6'd0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (post) begin
      cnt_d = 8'd0;
      rd_d  = 8'd0;
      if (tail_q) begin
        tail_d  = 1'b0;
        final_d = 1'b1;
        state_d = EMIT_CODE;
      end else if (final_q) begin
        state_d = EMIT_DELIM;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  // Output byte follows the next state, so it only moves on a handshake or block close.
  always_comb begin
    m_vld_d = (state_d != COLLECT);
    case (state_d)
      EMIT_CODE: m_dat_d = cnt_d + 8'd1;
      EMIT_DATA: m_dat_d = blk_q[rd_d];
      default:   m_dat_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      hold_q  <= 32'd0;
      held_q  <= 1'b0;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      rd_q    <= 8'd0;
      smp_q   <= 6'd0;
      final_q <= 1'b0;
      tail_q  <= 1'b0;
      m_dat_q <= 8'h00;
      m_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      smp_q   <= smp_d;
      final_q <= final_d;
      tail_q  <= tail_d;
      m_dat_q <= m_dat_d;
      m_vld_q <= m_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (blk_we) blk_q[cnt_q] <= cur_byte;
  end
endmodule

// File: tb/tb_cobs_sample_framer.sv
// Directed and randomised checks of the COBS sample framer at 1, 4 and 63 samples per frame.
module tb_cobs_sample_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cobs_sample_framer_if #(.W(32)) s1 ();
  cobs_sample_framer_if #(.W(8))  m1 ();
  cobs_sample_framer_if #(.W(32)) s4 ();
  cobs_sample_framer_if #(.W(8))  m4 ();
  cobs_sample_framer_if #(.W(32)) s63 ();
  cobs_sample_framer_if #(.W(8))  m63 ();

  cobs_sample_framer #(.SAMPLES_PER_FRAME(1))  dut1  (.clk(clk), .rst(rst), .s(s1),  .m(m1));
  cobs_sample_framer #(.SAMPLES_PER_FRAME(4))  dut4  (.clk(clk), .rst(rst), .s(s4),  .m(m4));
  cobs_sample_framer #(.SAMPLES_PER_FRAME(63)) dut63 (.clk(clk), .rst(rst), .s(s63), .m(m63));

  typedef struct packed {
    logic [31:0] smp;
    logic [3:0]  lat;
    logic [47:0] exp;
  } vec_t;

  vec_t        vt [6];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  got [$];
  logic [7:0]  rx  [$];
  logic [7:0]  dec [$];
  logic [31:0] smps [$];
  logic [31:0] w;
  logic [7:0]  eb, prev_dat;
  int          sviol, first, sent, dl, f2n, e, frames, stab_bad, idx;
  bit          done, stall_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int k);
    logic [7:0] b;
    b = 8'(8'h21 + 4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // One sample through the single-sample framer with m.tready held high.
  task automatic run1(input logic [31:0] smp);
    int n;
    got.delete();
    sviol = 0;
    first = -1;
    done  = 0;
    @(negedge clk);
    chk("idle_s_tready", 32'(s1.tready), 32'd1);
    s1.tdata  = smp;
    s1.tvalid = 1'b1;
    @(negedge clk);
    s1.tvalid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      if (s1.tready) sviol++;
      if (m1.tvalid) begin
        if (first < 0) first = n;
        got.push_back(m1.tdata);
        if (m1.tdata == 8'h00) done = 1;
      end
      @(negedge clk);
      n++;
    end
    chk("s_tready_after_delim", 32'(s1.tready), 32'd1);
  endtask

  initial begin
    vt[0] = '{32'h04030201, 4'd4, 48'h050102030400};
    vt[1] = '{32'h00000000, 4'd1, 48'h010101010100};
    vt[2] = '{32'h00020100, 4'd1, 48'h010301020100};
    vt[3] = '{32'h11002233, 4'd3, 48'h033322021100};
    vt[4] = '{32'h000000AB, 4'd2, 48'h02AB01010100};
    vt[5] = '{32'hFF00FF00, 4'd1, 48'h0102FF02FF00};

    s1.tvalid = 1'b0;  s1.tdata = '0;  m1.tready = 1'b1;
    s4.tvalid = 1'b0;  s4.tdata = '0;  m4.tready = 1'b1;
    s63.tvalid = 1'b0; s63.tdata = '0; m63.tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_m_tvalid", 32'(m1.tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m1.tdata), 32'd0);
    chk("rst_s_tready", 32'(s1.tready), 32'd1);
    chk("rst_s_tready_4", 32'(s4.tready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      run1(vt[v].smp);
      chk($sformatf("v%0d_len", v), 32'(got.size()), 32'd6);
      chk($sformatf("v%0d_latency", v), 32'(first), 32'(vt[v].lat));
      chk($sformatf("v%0d_s_tready_busy", v), 32'(sviol), 32'd0);
      for (int i = 0; i < 6; i++) begin
        eb = vt[v].exp[47 - 8 * i -: 8];
        chk($sformatf("v%0d_byte%0d", v, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(eb));
      end
    end

    // 63 all-ones samples per frame: FD, 252 x FF, 00, three frames back to back.
    got.delete();
    s63.tdata  = 32'hFFFFFFFF;
    s63.tvalid = 1'b1;
    for (int c = 0; c < 3000 && got.size() < 762; c++) begin
      @(negedge clk);
      if (m63.tvalid) got.push_back(m63.tdata);
    end
    s63.tvalid = 1'b0;
    chk("f63_len", 32'(got.size()), 32'd762);
    for (int f = 0; f < 3; f++) begin
      e = 0;
      for (int j = 0; j < 254; j++) begin
        eb = (j == 0) ? 8'hFD : ((j == 253) ? 8'h00 : 8'hFF);
        idx = f * 254 + j;
        if (idx >= got.size() || got[idx] !== eb) e++;
      end
      chk($sformatf("f63_frame%0d", f), 32'(e), 32'd0);
    end

    // Random traffic on the 4-sample framer, decoded by a reference COBS decoder.
    smps.delete();
    for (int k = 0; k < 40; k++) begin
      for (int b = 0; b < 4; b++)
        w[8 * b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      smps.push_back(w);
    end
    rx.delete();
    sent = 0; dl = 0; stab_bad = 0; stall_prev = 0; prev_dat = 8'h00;
    for (int c = 0; c < 20000 && !(sent == 40 && dl == 10); c++) begin
      @(negedge clk);
      if (stall_prev && !(m4.tvalid && m4.tdata == prev_dat)) stab_bad++;
      if (sent < 40) begin
        s4.tvalid = 1'($urandom_range(0, 1));
        s4.tdata  = smps[sent];
      end else begin
        s4.tvalid = 1'b0;
      end
      if (s4.tvalid && s4.tready) sent++;
      m4.tready = 1'($urandom_range(0, 1));
      if (m4.tvalid && m4.tready) begin
        rx.push_back(m4.tdata);
        if (m4.tdata == 8'h00) dl++;
      end
      stall_prev = m4.tvalid && !m4.tready;
      prev_dat   = m4.tdata;
    end
    s4.tvalid = 1'b0;
    m4.tready = 1'b1;
    dec.delete();
    frames = 0;
    idx = 0;
    while (idx < rx.size()) begin
      eb = rx[idx];
      idx++;
      if (eb == 8'h00) begin
        frames++;
      end else begin
        for (int k = 1; k < eb && idx < rx.size(); k++) begin
          dec.push_back(rx[idx]);
          idx++;
        end
        if (idx < rx.size() && rx[idx] != 8'h00) dec.push_back(8'h00);
      end
    end
    chk("rand_frames", 32'(frames), 32'd10);
    chk("rand_dec_len", 32'(dec.size()), 32'd160);
    chk("rand_stable", 32'(stab_bad), 32'd0);
    e = 0;
    for (int k = 0; k < 160; k++)
      if (k >= dec.size() || dec[k] !== smps[k / 4][8 * (k % 4) +: 8]) e++;
    chk("rand_payload", 32'(e), 32'd0);

    // Frame 1 complete, then reset in the middle of frame 2's data bytes.
    got.delete();
    sent = 0; dl = 0; f2n = 0;
    m4.tready = 1'b1;
    for (int c = 0; c < 400 && !(dl == 1 && f2n == 3); c++) begin
      @(negedge clk);
      s4.tvalid = (sent < 8);
      s4.tdata  = mk(sent);
      if (s4.tvalid && s4.tready) sent++;
      if (m4.tvalid) begin
        if (dl == 0) begin
          got.push_back(m4.tdata);
          if (m4.tdata == 8'h00) dl = 1;
        end else begin
          f2n++;
        end
      end
    end
    chk("f2_in_data", 32'(f2n), 32'd3);
    e = 0;
    for (int i = 0; i < 18; i++) begin
      eb = (i == 0) ? 8'h11 : ((i == 17) ? 8'h00 : 8'(8'h20 + i));
      if (i >= got.size() || got[i] !== eb) e++;
    end
    chk("f1_bytes", 32'(e), 32'd0);
    rst = 1'b1;
    s4.tvalid = 1'b0;
    @(negedge clk);
    chk("midrst_m_tvalid", 32'(m4.tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s4.tready), 32'd1);
    rst = 1'b0;

    got.delete();
    sent = 8; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      s4.tvalid = (sent < 12);
      s4.tdata  = mk(sent);
      if (s4.tvalid && s4.tready) sent++;
      if (m4.tvalid) begin
        got.push_back(m4.tdata);
        if (m4.tdata == 8'h00) done = 1;
      end
    end
    s4.tvalid = 1'b0;
    chk("f3_len", 32'(got.size()), 32'd18);
    e = 0;
    for (int i = 0; i < 18; i++) begin
      eb = (i == 0) ? 8'h11 : ((i == 17) ? 8'h00 : 8'(8'h40 + i));
      if (i >= got.size() || got[i] !== eb) e++;
    end
    chk("f3_bytes", 32'(e), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
